// File: rtl/pwm_capture_pkg.sv
// pwm_capture shared types: FSM states, CTRL/STATUS bit positions.
// Optional glitch filter is enabled with PWM_CAPTURE_FILTER_EN.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_POL     = 1;
  localparam int CTRL_PRESC   = 2;
  localparam int PRESC_W      = 5;
  localparam int CTRL_CAPIE   = 7;
  localparam int CTRL_OVFIE   = 8;
  localparam int CTRL_ONESHOT = 9;
  localparam int CTRL_W       = 10;

  localparam int ST_CAPF = 0;
  localparam int ST_OVFF = 1;

  function automatic logic [31:0] presc_mask(
    input logic [PRESC_W-1:0] p
  );
    return (32'd1 << p) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// sync_edge: 2-FF synchroniser, polarity, registered edge detect.
// PWM_CAPTURE_FILTER_EN adds a FILT_LEN-sample stability filter.
module sync_edge
`ifdef PWM_CAPTURE_FILTER_EN
#(
  parameter int FILT_LEN = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic pol,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic lvl;

  // two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic          filt;
  logic [FW-1:0] fcnt;

  // follow the input only after FILT_LEN differing samples in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT_LEN - 1)) begin
      filt <= s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign lvl = filt ^ pol;
`else
  assign lvl = s2 ^ pol;
`endif

  // registered edge strobes, one cycle wide
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= lvl;
      rise  <= lvl & ~level;
      fall  <= ~lvl & level;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a pulse train.
// Build option PWM_CAPTURE_FILTER_EN enables the input glitch filter.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef PWM_CAPTURE_FILTER_EN
  ,
  parameter int FILT_LEN = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             ctrl_we,
  input  logic [1:0]       stat_clr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] o_ctrl,
  output logic [1:0]       o_status,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             valid,
  output logic             int_cap,
  output logic             int_ovf
);

  logic [CTRL_W-1:0] ctrl;
  state_t            state;
  logic [31:0]       pcnt;
  logic [31:0]       pmask;
  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  hi_lat;
  logic              capf;
  logic              ovff;
  logic              level;
  logic              rise;
  logic              fall;
  logic              en;
  logic              tick;
  logic              meas;
  logic              reconf;
  logic              run;
  logic              ovf_evt;
  logic              cap_evt;
  logic              one_clr;
  logic              unused;

`ifdef PWM_CAPTURE_FILTER_EN
  sync_edge #(.FILT_LEN(FILT_LEN)) u_sync (
`else
  sync_edge u_sync (
`endif
    .clk   (clk),
    .rst   (rst),
    .pin   (pwm_in),
    .pol   (ctrl[CTRL_POL]),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign en      = ctrl[CTRL_EN];
  assign pmask   = presc_mask(ctrl[CTRL_PRESC +: PRESC_W]);
  assign tick    = (pcnt & pmask) == pmask;
  assign meas    = (state == MEAS_HIGH) || (state == MEAS_LOW);
  assign reconf  = ctrl_we && data_in[CTRL_EN] &&
                   ((data_in[CTRL_POL] != ctrl[CTRL_POL]) ||
                    (data_in[CTRL_PRESC +: PRESC_W] !=
                     ctrl[CTRL_PRESC +: PRESC_W]));
  assign run     = en && !reconf;
  assign ovf_evt = run && meas && tick && (&cnt);
  assign cap_evt = run && (state == MEAS_LOW) && rise && !ovf_evt;
  assign one_clr = cap_evt && ctrl[CTRL_ONESHOT];

  assign o_ctrl   = {{(WIDTH - CTRL_W){1'b0}}, ctrl};
  assign o_status = {ovff, capf};
  assign int_cap  = capf & ctrl[CTRL_CAPIE];
  assign int_ovf  = ovff & ctrl[CTRL_OVFIE];
  assign unused   = ^{level, data_in[WIDTH-1:CTRL_W]};

  // CTRL register and sticky flags; set beats clear, write beats oneshot
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
      capf <= 1'b0;
      ovff <= 1'b0;
    end else begin
      if (ctrl_we) begin
        ctrl <= data_in[CTRL_W-1:0];
      end else if (one_clr) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
      capf <= cap_evt | (capf & ~stat_clr[ST_CAPF]);
      ovff <= ovf_evt | (ovff & ~stat_clr[ST_OVFF]);
    end
  end

  // prescaler, phase-aligned to each rising edge
  always_ff @(posedge clk) begin
    if (rst || !en || rise) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 32'd1;
    end
  end

  // measurement FSM, tick counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_lat   <= '0;
      o_period <= '0;
      o_high   <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= cap_evt;
      if (!en) begin
        state  <= IDLE;
        cnt    <= '0;
        hi_lat <= '0;
      end else if (reconf) begin
        state <= WAIT_RISE;
        cnt   <= '0;
      end else begin
        if (rise) begin
          cnt <= '0;
        end else if (meas && tick && !(&cnt)) begin
          cnt <= cnt + 1'b1;
        end
        unique case (state)
          IDLE: state <= WAIT_RISE;
          WAIT_RISE: begin
            if (rise) state <= MEAS_HIGH;
          end
          MEAS_HIGH: begin
            if (ovf_evt) begin
              state <= WAIT_RISE;
            end else if (fall) begin
              hi_lat <= cnt + WIDTH'(tick);
              state  <= MEAS_LOW;
            end
          end
          MEAS_LOW: begin
            if (ovf_evt) begin
              state <= WAIT_RISE;
            end else if (rise) begin
              o_period <= cnt + WIDTH'(tick);
              o_high   <= hi_lat;
              state    <= ctrl[CTRL_ONESHOT] ? IDLE : MEAS_HIGH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed pulse trains vs. arithmetic model.
// Filter scenario runs only when PWM_CAPTURE_FILTER_EN is defined.
module tb_pwm_capture;

  localparam int W = 12;
  localparam logic [W-1:0] EN  = 12'h001;
  localparam logic [W-1:0] POL = 12'h002;
  localparam logic [W-1:0] CIE = 12'h080;
  localparam logic [W-1:0] OIE = 12'h100;
  localparam logic [W-1:0] ONE = 12'h200;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctrl_we;
  logic [1:0]   stat_clr;
  logic [W-1:0] data_in;
  logic [W-1:0] o_ctrl;
  logic [1:0]   o_status;
  logic [W-1:0] o_period;
  logic [W-1:0] o_high;
  logic         valid;
  logic         int_cap;
  logic         int_ovf;

  logic gen_pin = 1'b0;
  logic man_pin = 1'b0;
  logic wave_on = 1'b0;
  logic glitch  = 1'b0;
  int   hi_t    = 4;
  int   lo_t    = 4;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (wave_on ? gen_pin : man_pin),
    .ctrl_we  (ctrl_we),
    .stat_clr (stat_clr),
    .data_in  (data_in),
    .o_ctrl   (o_ctrl),
    .o_status (o_status),
    .o_period (o_period),
    .o_high   (o_high),
    .valid    (valid),
    .int_cap  (int_cap),
    .int_ovf  (int_ovf)
  );

  // pulse train generator, driven away from the sampling edge
  initial begin
    forever begin
      if (wave_on) begin
        gen_pin = 1'b1;
        if (glitch) begin
          repeat (3) @(negedge clk);
          gen_pin = 1'b0;
          repeat (2) @(negedge clk);
          gen_pin = 1'b1;
          repeat (3) @(negedge clk);
        end else begin
          repeat (hi_t) @(negedge clk);
        end
        gen_pin = 1'b0;
        repeat (lo_t) @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic wr_ctrl(input logic [W-1:0] v);
    @(negedge clk);
    ctrl_we = 1'b1;
    data_in = v;
    @(negedge clk);
    ctrl_we = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, " timeout"}, 0, 1);
  endtask

  task automatic run_wave(input string tag, input int h, input int l,
                          input logic [W-1:0] cfg, input int n);
    int  p;
    int  per;
    int  hi;
    int  last;
    bit  ok;
    p   = int'(cfg[6:2]);
    per = (h + l) >> p;
    hi  = (cfg[1] ? l : h) >> p;
    wr_ctrl('0);
    hi_t    = h;
    lo_t    = l;
    wave_on = 1'b1;
    repeat (40) @(negedge clk);
    wr_ctrl(cfg & ~EN);
    repeat (40) @(negedge clk);
    wr_ctrl(cfg | EN);
    wait_valid(tag, ok);
    if (!ok) return;
    last = cyc;
    for (int i = 0; i < n; i++) begin
      wait_valid(tag, ok);
      if (!ok) return;
      check({tag, " period"}, o_period, per);
      check({tag, " high"}, o_high, hi);
      check({tag, " gap"}, cyc - last, h + l);
      last = cyc;
    end
  endtask

  initial begin
    bit   ok;
    int   n;
    int   nv;
    logic [W-1:0] per0;
    logic [W-1:0] hi0;
    int   h;
    int   l;
    logic [W-1:0] cfg;

    rst      = 1'b1;
    ctrl_we  = 1'b0;
    stat_clr = 2'b00;
    data_in  = '0;
    repeat (3) @(negedge clk);
    check("rst ctrl", o_ctrl, 0);
    check("rst status", o_status, 0);
    check("rst period", o_period, 0);
    check("rst high", o_high, 0);
    check("rst valid", valid, 0);
    check("rst int_cap", int_cap, 0);
    check("rst int_ovf", int_ovf, 0);
    rst = 1'b0;

    wr_ctrl(12'hFFE);
    check("ctrl upper bits", o_ctrl, 12'h3FE);
    wr_ctrl('0);

    run_wave("p0 3/5", 3, 5, '0, 3);

    run_wave("p2 12/20", 12, 20, (W'(2) << 2) | CIE, 2);
    check("int_cap set", int_cap, 1);
    stat_clr = 2'b01;
    @(negedge clk);
    stat_clr = 2'b00;
    check("capf cleared", o_status[0], 0);
    check("int_cap cleared", int_cap, 0);
    stat_clr = 2'b01;
    wait_valid("set wins", ok);
    check("set beats clear", o_status[0], 1);
    @(negedge clk);
    check("clear held", o_status[0], 0);
    stat_clr = 2'b00;

    run_wave("pol 5/3", 5, 3, POL, 2);

    wait_valid("pre-rst", ok);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst ctrl", o_ctrl, 0);
    check("mid rst period", o_period, 0);
    check("mid rst high", o_high, 0);
    check("mid rst status", o_status, 0);
    nv = 0;
    repeat (60) begin
      @(negedge clk);
      if (valid) nv++;
    end
    check("no valid after rst", nv, 0);

    for (int k = 0; k < 6; k++) begin
      h   = $urandom_range(1, 12);
      l   = $urandom_range(1, 12);
      cfg = (W'($urandom_range(0, 3)) << 2) |
            ($urandom_range(0, 1) ? POL : '0);
      run_wave($sformatf("rnd%0d h%0d l%0d c%0h", k, h, l, cfg),
               h, l, cfg, 2);
    end

    wr_ctrl('0);
    hi_t = 4;
    lo_t = 4;
    repeat (40) @(negedge clk);
    wr_ctrl(ONE);
    repeat (10) @(negedge clk);
    wr_ctrl(ONE | EN);
    nv   = 0;
    per0 = '0;
    hi0  = '0;
    repeat (120) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        per0 = o_period;
        hi0  = o_high;
      end
    end
    check("oneshot strobes", nv, 1);
    check("oneshot period", per0, 8);
    check("oneshot high", hi0, 4);
    check("oneshot ctrl", o_ctrl, ONE);

    wr_ctrl('0);
    wave_on  = 1'b0;
    man_pin  = 1'b0;
    stat_clr = 2'b11;
    @(negedge clk);
    stat_clr = 2'b00;
    wr_ctrl(OIE);
    repeat (10) @(negedge clk);
    wr_ctrl(OIE | EN);
    repeat (10) @(negedge clk);
    per0    = o_period;
    hi0     = o_high;
    man_pin = 1'b1;
    n  = 0;
    nv = 0;
    while (n < 6000 && !o_status[1]) begin
      @(negedge clk);
      n++;
      if (n == 5) man_pin = 1'b0;
      if (valid) nv++;
    end
    check("ovf latency ok", (n >= 4096 && n <= 4104), 1);
    check("ovf no capture", nv, 0);
    check("ovf period kept", o_period, per0);
    check("ovf high kept", o_high, hi0);
    check("int_ovf", int_ovf, 1);
    hi_t    = 3;
    lo_t    = 5;
    wave_on = 1'b1;
    wait_valid("post ovf", ok);
    if (ok) begin
      check("post ovf period", o_period, 8);
      check("post ovf high", o_high, 3);
    end

`ifdef PWM_CAPTURE_FILTER_EN
    glitch = 1'b1;
    run_wave("filter 8/8", 8, 8, '0, 2);
    glitch = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
